skew_prefix_adder8: RTL and testbench

Registered 8-bit unsigned adder built on an explicit skewed parallel-prefix carry network.
- Low-order carries are resolved serially.
- High-order carries are resolved by a log-depth tree.
- This matches datapaths where upper operand bits arrive later than lower bits.
- The block feeds downstream accumulators/ALU slices with a single-cycle registered {cout, sum} and a valid flag.

---
 rtl/skew_prefix_pkg.sv | 20 ++
 rtl/skew_prefix_adder8_cell.sv | 19 +
 rtl/skew_prefix_adder8.sv | 133 +++++++++++++
 tb/tb_skew_prefix_adder8.sv | 124 ++++++++++++
 4 files changed

// File: rtl/skew_prefix_pkg.sv
// Shared constants, generate/propagate pair type and prefix operator for skew_prefix_adder8.
package skew_prefix_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SERIAL_BITS = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // (G,P) o (G',P') = (G | P&G', P&P'); hi is the more significant span
  function automatic gp_t prefix_op(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/skew_prefix_adder8_cell.sv
// One prefix operator node, shared by the serial chain and the Sklansky tree.
module prefix_cell
  import skew_prefix_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  gp_t res_c;

  assign res_c = prefix_op('{g: g_hi, p: p_hi}, '{g: g_lo, p: p_lo});
  assign g     = res_c.g;
  assign p     = res_c.p;

endmodule

// File: rtl/skew_prefix_adder8.sv
// Registered adder with a serial low-order carry chain and a Sklansky upper tree.
// Optional carry-in port enabled by defining SKEWPREFIX_CIN_EN.
module skew_prefix_adder8
  import skew_prefix_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SERIAL_BITS = DEF_SERIAL_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SKEWPREFIX_CIN_EN
  input  logic             cin,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  // Serial section always holds at least bit 0 and never exceeds the word.
  localparam int unsigned SER = (SERIAL_BITS < 1) ? 1 :
                                ((SERIAL_BITS > WIDTH) ? WIDTH : SERIAL_BITS);
  localparam int unsigned UPW = WIDTH - SER;
  localparam int unsigned LVL = (UPW > 1) ? $clog2(UPW) : 0;

  logic             cin_c;
  gp_t              gp     [WIDTH];
  logic             grp_g  [WIDTH];
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

`ifdef SKEWPREFIX_CIN_EN
  assign cin_c = cin;
`else
  assign cin_c = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      gp[i].g = a[i] & b[i];
      gp[i].p = a[i] ^ b[i];
    end
  end

  // Low-order ripple chain; carry-in is folded into the bit-0 node.
  for (genvar i = 0; i < int'(SER); i++) begin : gen_ser
    logic node_g;
    logic node_p;
    if (i == 0) begin : gen_first
      prefix_cell u_cell (
        .g_hi (gp[0].g),
        .p_hi (gp[0].p),
        .g_lo (cin_c),
        .p_lo (1'b0),
        .g    (node_g),
        .p    (node_p)
      );
    end else begin : gen_next
      prefix_cell u_cell (
        .g_hi (gp[i].g),
        .p_hi (gp[i].p),
        .g_lo (gen_ser[i-1].node_g),
        .p_lo (gen_ser[i-1].node_p),
        .g    (node_g),
        .p    (node_p)
      );
    end
    assign grp_g[i] = node_g;
  end

  // Sklansky tree over the late-arriving upper bits, indexed relative to SER.
  for (genvar k = 0; k <= int'(LVL); k++) begin : gen_lvl
    for (genvar j = 0; j < int'(UPW); j++) begin : gen_bit
      logic node_g;
      logic node_p;
      if (k == 0) begin : gen_leaf
        assign node_g = gp[int'(SER) + j].g;
        assign node_p = gp[int'(SER) + j].p;
      end else if (((j >> (k - 1)) & 1) == 1) begin : gen_comb
        localparam int SRC = ((j >> (k - 1)) << (k - 1)) - 1;
        prefix_cell u_cell (
          .g_hi (gen_lvl[k-1].gen_bit[j].node_g),
          .p_hi (gen_lvl[k-1].gen_bit[j].node_p),
          .g_lo (gen_lvl[k-1].gen_bit[SRC].node_g),
          .p_lo (gen_lvl[k-1].gen_bit[SRC].node_p),
          .g    (node_g),
          .p    (node_p)
        );
      end else begin : gen_pass
        assign node_g = gen_lvl[k-1].gen_bit[j].node_g;
        assign node_p = gen_lvl[k-1].gen_bit[j].node_p;
      end
    end
  end

  // Single final level joins each upper group prefix with the serial result.
  for (genvar j = 0; j < int'(UPW); j++) begin : gen_fin
    logic unused_p;
    prefix_cell u_cell (
      .g_hi (gen_lvl[LVL].gen_bit[j].node_g),
      .p_hi (gen_lvl[LVL].gen_bit[j].node_p),
      .g_lo (gen_ser[SER-1].node_g),
      .p_lo (gen_ser[SER-1].node_p),
      .g    (grp_g[int'(SER) + j]),
      .p    (unused_p)
    );
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_c[i] = gp[i].p ^ ((i == 0) ? cin_c : grp_g[i-1]);
    end
    cout_c = grp_g[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_c;
        cout <= cout_c;
      end
    end
  end

endmodule

// File: tb/tb_skew_prefix_adder8.sv
// Directed self-checking bench for skew_prefix_adder8 (honours SKEWPREFIX_CIN_EN).
module tb_skew_prefix_adder8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  skew_prefix_adder8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef SKEWPREFIX_CIN_EN
    .cin       (cin),
`endif
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, return just after the next rising edge.
  task automatic apply(input logic v, input logic [7:0] x, input logic [7:0] y, input logic ci);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] res, input logic vld);
    check(tag, {cout, sum}, res);
    check({tag, "_valid"}, 9'(out_valid), 9'(vld));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'd200;
    b        = 8'd100;
    cin      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 9'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 8'd200, 8'd100, 1'b0);
    expect_out("200+100", {1'b1, 8'd44}, 1'b1);

    apply(1'b1, 8'd0,   8'd0,   1'b0); expect_out("0+0",     {1'b0, 8'd0},   1'b1);
    apply(1'b1, 8'd255, 8'd1,   1'b0); expect_out("255+1",   {1'b1, 8'd0},   1'b1);
    apply(1'b1, 8'd255, 8'd255, 1'b0); expect_out("255+255", {1'b1, 8'd254}, 1'b1);
    apply(1'b1, 8'd170, 8'd85,  1'b0); expect_out("170+85",  {1'b0, 8'd255}, 1'b1);

    apply(1'b1, 8'd63, 8'd63, 1'b0); expect_out("63+63", {1'b0, 8'd126}, 1'b1);
    apply(1'b0, 8'd1,  8'd1,  1'b0); expect_out("hold",  {1'b0, 8'd126}, 1'b0);

    apply(1'b1, 8'd63, 8'd1, 1'b0); expect_out("63+1", {1'b0, 8'd64}, 1'b1);

    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        apply(1'b1, 8'(i), 8'(j), 1'b0);
        check("lowq", {cout, sum}, 9'(i) + 9'(j));
      end
    end

    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        apply(1'b1, 8'(i), 8'(j), 1'b0);
        check("sweep", {cout, sum}, 9'(i) + 9'(j));
      end
    end

`ifdef SKEWPREFIX_CIN_EN
    apply(1'b1, 8'd255, 8'd0,   1'b1); expect_out("255+0+1",   {1'b1, 8'd0}, 1'b1);
    apply(1'b1, 8'd127, 8'd128, 1'b1); expect_out("127+128+1", {1'b1, 8'd0}, 1'b1);
    for (int i = 0; i < 256; i += 3) begin
      for (int j = 0; j < 256; j++) begin
        apply(1'b1, 8'(i), 8'(j), 1'b1);
        check("sweep_cin", {cout, sum}, 9'(i) + 9'(j) + 9'd1);
      end
    end
`endif

    // Reset asserted between clock edges must clear outputs without an edge.
    apply(1'b1, 8'd100, 8'd100, 1'b0);
    apply(1'b1, 8'd250, 8'd10,  1'b0);
    expect_out("pre_rst", {1'b1, 8'd4}, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 9'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 8'd10, 8'd20, 1'b0);
    expect_out("post_rst", {1'b0, 8'd30}, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
